output_interface: RTL and testbench
===================================

// Module: output_interface
// PURPOSE
// - Return path of the accelerator: accepts the 4-bit command pulse from the UART input side, streams vector A/B
//   BRAM contents or the 32-bit scalar result out over UART TX (8N1, LSB first), then pulses done.
// - done ends the receive side's COMM wait. Commands CMD_LOAD_A/CMD_LOAD_B are ignored (no done).
// PARAMETERS
// - NBytes        1024  bytes per vector (1..1024); last address NBytes-1
// - CLKS_PER_BIT  100   clk cycles per UART bit (100 MHz / 100 = 1 Mbaud)
// PORTS
// - clk          in   1   system clock, single domain
// - reset        in   1   synchronous, active-high
// - command      in   4   one-cycle command pulse; 0 = no command
// - result_word  in   32  scalar accelerator result, sampled on command accept
// - bramA_data   in   8   BRAM_A read data, valid 1 cycle after bramA_en
// - bramB_data   in   8   BRAM_B read data, valid 1 cycle after bramB_en
// - bramA_en     out  1   BRAM_A read enable
// - bramB_en     out  1   BRAM_B read enable
// - bram_addr    out  10  BRAM read address
// - uart_tx      out  1   serial output, idles high
// - busy         out  1   high from command accept until done
// - done         out  1   one-cycle pulse, transfer finished
// BEHAVIOUR
// - Reset values: state IDLE, bram_addr 0, bramA_en 0, bramB_en 0, busy 0, done 0, uart_tx 1, byte index 0.
// - Commands: 2 = CMD_READ_A, 3 = CMD_READ_B, 4 = CMD_RESULT.
//   - 0/1 are ignored.
//   - 5..15: IDLE->FIN; done pulses the cycle after command.
// - Commands are accepted only in IDLE; nonzero command while busy is dropped (no queueing).
// - FSM: IDLE -> RD -> WAIT -> LOAD -> SEND -> (NEXT -> RD | FIN) ; FIN -> IDLE.
//   - RD: assert bramX_en for one cycle with bram_addr.
//   - WAIT: BRAM latency; capture bramX_data into tx_byte.
//   - LOAD: one-cycle Tx_DV pulse to uart_tx with tx_byte.
//   - SEND: hold until Tx_Done.
//   - NEXT: if addr==NBytes-1 go to FIN, else addr+1 and go to RD.
// - CMD_RESULT skips RD/WAIT and sends result_word in 4 bytes, byte 0 = [7:0] first, byte 3 = [31:24] last.
//   The latched copy is used; later changes of result_word do not affect the transfer.
// - bram_addr is 10 bits and clears to 0 on accept.
//   - It never wraps: a transfer ends at NBytes-1, so the next transfer starts at 0.
// - Frame: start bit 0, 8 data bits LSB first, stop bit 1, each CLKS_PER_BIT cycles = 10*CLKS_PER_BIT per byte.
//   - Inter-byte gap (Tx_Done to next start bit) <= 5 cycles for vectors, <= 3 for result bytes.
// - done is high exactly one cycle (state FIN); busy drops in the same cycle done rises.
// - A command arriving in the FIN cycle is dropped.
// - bramA_en/bramB_en are never high together; both are 0 outside RD.
// - Reset mid-frame: next cycle uart_tx=1, all outputs at reset values, no done pulse.
//   - The partial frame is abandoned; the next command restarts from address/byte 0.
// STRUCTURE
// - Package acc_pkg: CMD_LOAD_A=4'd0, CMD_LOAD_B=4'd1, CMD_READ_A=4'd2, CMD_READ_B=4'd3, CMD_RESULT=4'd4;
//   BRAM_AW=10; out_state_t enum {IDLE,RD,WAIT,LOAD,SEND,NEXT,FIN}.
// - One sub-module: uart_tx #(CLKS_PER_BIT), the counterpart of the existing uart_rx.
//   - Ports: Clock, reset, Tx_DV, Tx_Byte[7:0], Tx_Active, Tx_Serial, Tx_Done.
//   - Tx_Done is a one-cycle pulse after the stop bit.
// - Control FSM and address/byte counters live in output_interface.
// TESTING (CLKS_PER_BIT=4, NBytes=8, BRAM models with 1-cycle latency, UART monitor decoding 8N1)
// - Reset, then idle 100 cycles -> uart_tx constant 1, done/busy/bram enables 0.
// - BRAM_A = 8'h10..8'h17, command=2 -> monitor gets 10,11,..,17 in order, bramB_en never 1, one done pulse,
//   busy high throughout.
// - result_word=32'hDEADBEEF, command=4; change result_word next cycle -> bytes EF,BE,AD,DE, then done.
// - command=0 and command=1 pulses -> no TX activity, no done; command=9 -> done one cycle later, no TX.
// - command=3 with command=2 pulsed mid-transfer -> only BRAM_B 8 bytes sent, exactly one done.
// - Reset asserted during 3rd data bit of byte 4 -> uart_tx=1 next cycle, no done.
//   - Then command=2 -> full 8-byte stream from address 0.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: command codes, BRAM address width and output FSM states shared by the accelerator return path
package acc_pkg;
  localparam logic [3:0] CMD_LOAD_A = 4'd0;
  localparam logic [3:0] CMD_LOAD_B = 4'd1;
  localparam logic [3:0] CMD_READ_A = 4'd2;
  localparam logic [3:0] CMD_READ_B = 4'd3;
  localparam logic [3:0] CMD_RESULT = 4'd4;
  localparam int BRAM_AW = 10;
  typedef enum logic [2:0] {IDLE, RD, WAIT, LOAD, SEND, NEXT, FIN} out_state_t;
endpackage

// File: rtl/output_interface_uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first, one-cycle Tx_Done pulse after the stop bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       Tx_DV,
  input  logic [7:0] Tx_Byte,
  output logic       Tx_Active,
  output logic       Tx_Serial,
  output logic       Tx_Done
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] clk_cnt;
  logic [3:0] bit_idx;
  logic [9:0] frame;
  always_ff @(posedge Clock) begin
    if (reset) begin
      Tx_Active <= 1'b0;
      Tx_Serial <= 1'b1;
      Tx_Done   <= 1'b0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      frame     <= '1;
    end else begin
      Tx_Done <= 1'b0;
      if (!Tx_Active) begin
        Tx_Serial <= 1'b1;
        if (Tx_DV) begin
          frame     <= {1'b1, Tx_Byte, 1'b0};
          Tx_Active <= 1'b1;
          Tx_Serial <= 1'b0;
          clk_cnt   <= '0;
          bit_idx   <= '0;
        end
      end else if (clk_cnt == LAST_CLK) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          Tx_Active <= 1'b0;
          Tx_Done   <= 1'b1;
          Tx_Serial <= 1'b1;
        end else begin
          bit_idx   <= bit_idx + 4'd1;
          frame     <= {1'b1, frame[9:1]};
          Tx_Serial <= frame[1];
        end
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/output_interface.sv
// output_interface: streams BRAM_A/BRAM_B contents or the latched scalar result over UART TX, then pulses done
module output_interface
  import acc_pkg::*;
#(
  parameter int NBytes       = 1024,
  parameter int CLKS_PER_BIT = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         command,
  input  logic [31:0]        result_word,
  input  logic [7:0]         bramA_data,
  input  logic [7:0]         bramB_data,
  output logic               bramA_en,
  output logic               bramB_en,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic               uart_tx,
  output logic               busy,
  output logic               done
);
  localparam logic [BRAM_AW-1:0] LAST_ADDR = BRAM_AW'(NBytes - 1);
  out_state_t state, next_state;
  logic [1:0] byte_idx;
  logic [7:0] tx_byte;
  logic [31:0] result_q;
  logic sel_b, is_res, tx_dv, tx_active, tx_done, accept;
  assign accept   = state == IDLE && command inside {CMD_READ_A, CMD_READ_B, CMD_RESULT};
  assign bramA_en = state == RD && !sel_b;
  assign bramB_en = state == RD && sel_b;
  assign busy     = state != IDLE && state != FIN;
  assign done     = state == FIN;
  assign tx_dv    = state == LOAD && !tx_active;
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = (command == CMD_READ_A || command == CMD_READ_B) ? RD :
                         command == CMD_RESULT ? LOAD :
                         command > CMD_RESULT ? FIN : IDLE;
      RD:   next_state = WAIT;
      WAIT: next_state = LOAD;
      LOAD: next_state = tx_active ? LOAD : SEND;
      SEND: next_state = tx_done ? NEXT : SEND;
      NEXT: next_state = is_res ? (byte_idx == 2'd3 ? FIN : LOAD) : (bram_addr == LAST_ADDR ? FIN : RD);
      FIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bram_addr <= '0;
      byte_idx  <= '0;
      tx_byte   <= '0;
      result_q  <= '0;
      sel_b     <= 1'b0;
      is_res    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        bram_addr <= '0;
        byte_idx  <= '0;
        sel_b     <= command == CMD_READ_B;
        is_res    <= command == CMD_RESULT;
        result_q  <= result_word;
        tx_byte   <= result_word[7:0];
      end
      if (state == WAIT) tx_byte <= sel_b ? bramB_data : bramA_data;
      // result bytes are shifted out of the latched copy, so result_word may change freely
      if (state == NEXT && is_res) begin
        byte_idx <= byte_idx + 2'd1;
        result_q <= result_q >> 8;
        tx_byte  <= result_q[15:8];
      end
      if (state == NEXT && !is_res && bram_addr != LAST_ADDR) bram_addr <= bram_addr + 1'b1;
    end
  end
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .Clock    (clk),
    .reset    (reset),
    .Tx_DV    (tx_dv),
    .Tx_Byte  (tx_byte),
    .Tx_Active(tx_active),
    .Tx_Serial(uart_tx),
    .Tx_Done  (tx_done)
  );
endmodule

// File: tb/tb_output_interface.sv
// tb_output_interface: table-driven command vectors plus hand sequences for abort, drop and reset corners
module tb_output_interface;
  localparam int CLKS = 4;
  localparam int NB = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] command = '0;
  logic [31:0] result_word = '0;
  logic [7:0] bramA_data, bramB_data;
  logic bramA_en, bramB_en, uart_tx, busy, done;
  logic [9:0] bram_addr;
  logic [7:0] mem_a [NB];
  logic [7:0] mem_b [NB];
  int checks = 0, errors = 0;
  int done_cnt = 0, a_cnt = 0, b_cnt = 0, both_cnt = 0, frame_err = 0;
  logic [7:0] rxq [$];
  string ctx = "";
  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] res;
    int          n;
    logic [63:0] bytes;
    int          dn;
    logic        dn1;
    logic        bsy;
    int          na;
    int          nb;
  } vec_t;
  vec_t tv [7];

  always #5 clk = ~clk;

  output_interface #(.NBytes(NB), .CLKS_PER_BIT(CLKS)) dut (
    .clk(clk), .reset(rst), .command(command), .result_word(result_word),
    .bramA_data(bramA_data), .bramB_data(bramB_data), .bramA_en(bramA_en), .bramB_en(bramB_en),
    .bram_addr(bram_addr), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (bramA_en) bramA_data <= mem_a[bram_addr[2:0]];
    if (bramB_en) bramB_data <= mem_b[bram_addr[2:0]];
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (bramA_en === 1'b1) a_cnt++;
    if (bramB_en === 1'b1) b_cnt++;
    if (bramA_en === 1'b1 && bramB_en === 1'b1) both_cnt++;
  end

  initial begin : monitor
    logic [7:0] d;
    logic stop;
    bit ab;
    int b;
    d = '0;
    stop = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        ab = 0;
        for (int j = 1; j <= 9 * CLKS + CLKS / 2; j++) begin
          @(negedge clk);
          if (rst) begin
            ab = 1;
            break;
          end
          if (j % CLKS == CLKS / 2) begin
            b = j / CLKS;
            if (b >= 1 && b <= 8) d[b-1] = uart_tx;
            else if (b == 9) stop = uart_tx;
          end
        end
        if (!ab) begin
          rxq.push_back(d);
          if (stop !== 1'b1) frame_err++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s%s: got %0h expected %0h", ctx, name, act, exp);
    end
  endtask

  task automatic wait_done(output int k, output int drop);
    k = 0;
    drop = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
      if (done !== 1'b1 && busy !== 1'b1) drop++;
    end
    check("done_seen", k < 3000, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int q0, d0, a0, b0, k, drop;
    q0 = rxq.size();
    d0 = done_cnt;
    a0 = a_cnt;
    b0 = b_cnt;
    ctx = $sformatf("cmd%0d ", v.cmd);
    @(negedge clk);
    command = v.cmd;
    result_word = v.res;
    @(negedge clk);
    command = '0;
    result_word = ~v.res;
    check("busy_after_accept", busy, v.bsy);
    check("done_next_cycle", done, v.dn1);
    if (v.dn != 0) begin
      wait_done(k, drop);
      if (v.bsy) check("busy_held", drop, 0);
      repeat (20) @(negedge clk);
    end else begin
      repeat (200) @(negedge clk);
    end
    check("rx_count", rxq.size() - q0, v.n);
    for (int j = 0; j < v.n && j < rxq.size() - q0; j++)
      check($sformatf("rx_byte%0d", j), rxq[q0+j], v.bytes[8*j+:8]);
    check("done_pulses", done_cnt - d0, v.dn);
    check("a_en_cycles", a_cnt - a0, v.na);
    check("b_en_cycles", b_cnt - b0, v.nb);
  endtask

  initial begin
    int viol, q0, d0, a0, k, drop;
    for (int i = 0; i < NB; i++) begin
      mem_a[i] = 8'h10 + 8'(i);
      mem_b[i] = 8'hA0 + 8'(i);
    end
    tv[0] = '{4'd2, 32'h0, 8, 64'h1716151413121110, 1, 1'b0, 1'b1, 8, 0};
    tv[1] = '{4'd3, 32'h0, 8, 64'hA7A6A5A4A3A2A1A0, 1, 1'b0, 1'b1, 0, 8};
    tv[2] = '{4'd4, 32'hDEADBEEF, 4, 64'h00000000DEADBEEF, 1, 1'b0, 1'b1, 0, 0};
    tv[3] = '{4'd0, 32'h0, 0, 64'h0, 0, 1'b0, 1'b0, 0, 0};
    tv[4] = '{4'd1, 32'h0, 0, 64'h0, 0, 1'b0, 1'b0, 0, 0};
    tv[5] = '{4'd9, 32'h0, 0, 64'h0, 1, 1'b1, 1'b0, 0, 0};
    tv[6] = '{4'd15, 32'h0, 0, 64'h0, 1, 1'b1, 1'b0, 0, 0};

    repeat (5) @(negedge clk);
    ctx = "reset ";
    check("uart_tx", uart_tx, 1);
    check("busy", busy, 0);
    check("done", done, 0);
    check("bram_en", {bramA_en, bramB_en}, 0);
    check("bram_addr", bram_addr, 0);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bramA_en !== 1'b0 || bramB_en !== 1'b0) viol++;
    end
    ctx = "idle ";
    check("quiet_cycles_violated", viol, 0);

    for (int i = 0; i < 7; i++) run_vec(tv[i]);

    ctx = "read_b_with_drop ";
    q0 = rxq.size();
    d0 = done_cnt;
    a0 = a_cnt;
    @(negedge clk);
    command = 4'd3;
    @(negedge clk);
    command = '0;
    repeat (100) @(negedge clk);
    command = 4'd2;
    @(negedge clk);
    command = '0;
    wait_done(k, drop);
    repeat (20) @(negedge clk);
    check("rx_count", rxq.size() - q0, 8);
    for (int j = 0; j < 8 && j < rxq.size() - q0; j++)
      check($sformatf("rx_byte%0d", j), rxq[q0+j], mem_b[j]);
    check("done_pulses", done_cnt - d0, 1);
    check("a_en_cycles", a_cnt - a0, 0);

    ctx = "fin_drop ";
    q0 = rxq.size();
    d0 = done_cnt;
    @(negedge clk);
    command = 4'd9;
    @(negedge clk);
    command = 4'd2;
    check("done_in_fin", done, 1);
    @(negedge clk);
    command = '0;
    repeat (200) @(negedge clk);
    check("rx_count", rxq.size() - q0, 0);
    check("done_pulses", done_cnt - d0, 1);

    ctx = "reset_mid_frame ";
    q0 = rxq.size();
    @(negedge clk);
    command = 4'd2;
    @(negedge clk);
    command = '0;
    k = 0;
    while (rxq.size() < q0 + 3 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    while (uart_tx !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("byte4_start_seen", k < 3000, 1);
    repeat (3 * CLKS + 1) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("uart_tx", uart_tx, 1);
    check("busy", busy, 0);
    check("done", done, 0);
    check("bram_addr", bram_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("bytes_before_abort", rxq.size() - q0, 3);
    check("done_pulses", done_cnt - d0, 0);
    run_vec(tv[0]);

    ctx = "global ";
    check("both_en_cycles", both_cnt, 0);
    check("stop_bit_errors", frame_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
